// File: rtl/ad_pkg.sv
// Shared types and constants for the ADC0809 ISA port controller.
// Holds the conversion FSM states and the status-port bit positions.
package ad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALE_S,
        START_S,
        WAIT_LO,
        WAIT_HI,
        RD_OE
    } state_t;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_VALID = 6;
    localparam int STAT_ERR   = 5;

endpackage

// File: rtl/ad_sync2.sv
// Two-flop synchroniser for signals arriving asynchronously to the system clock.
// Both stages clear to 0 under the synchronous active-low reset.
module ad_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ad_adc0809_ctrl.sv
// ISA I/O-port controller for an ADC0809: a CPU OUT starts a conversion, IN returns data/status.
// Optional interrupt output is built only when the ADC_IRQ_EN macro is defined.
module ad_adc0809_ctrl
    import ad_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR    = 10'b0111111000,
    parameter int         ALE_CYCLES   = 2,
    parameter int         START_CYCLES = 2,
    parameter int         OE_CYCLES    = 3,
    parameter int         EOC_TIMEOUT  = 4096
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IOR,
    input  logic       IOW,
    input  logic       AEN,
    input  logic [9:0] A,
    input  logic [7:0] DATAIN,
    output logic [7:0] DATAOUT,
    output logic       READ,
    output logic       WRITE,
    input  logic [7:0] ADC_D,
    input  logic       EOC,
    output logic       ALE,
    output logic       START,
    output logic       OE,
    output logic [2:0] ADDR,
    output logic       IRQ
);

    localparam int CW = $clog2(EOC_TIMEOUT + 1);
    localparam int START_S_LEN = (START_CYCLES > 1) ? (START_CYCLES - 1) : 1;
    localparam logic [9:0]    STAT_ADDR  = BASE_ADDR + 10'd1;
    localparam logic [CW-1:0] ALE_LAST   = CW'(ALE_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_S_LEN - 1);
    localparam logic [CW-1:0] OE_LAST    = CW'(OE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(EOC_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;

    logic       ior_s, iow_s, eoc_s;
    logic       ior_d, iow_d;
    logic       data_sel, stat_sel;
    logic       write_ev, rd_end_ev;
    logic       done, timed_out;

    logic [2:0] addr;
    logic [7:0] data;
    logic       busy, valid, err;
    logic [7:0] status;

    // Only the channel-select bits of the written byte matter.
    logic       unused_datain;
    assign unused_datain = ^DATAIN[7:3];

    ad_sync2 u_sync_ior (.clk(CLK), .rst_n(RST_N), .d(IOR), .q(ior_s));
    ad_sync2 u_sync_iow (.clk(CLK), .rst_n(RST_N), .d(IOW), .q(iow_s));
    ad_sync2 u_sync_eoc (.clk(CLK), .rst_n(RST_N), .d(EOC), .q(eoc_s));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ior_d <= 1'b0;
            iow_d <= 1'b0;
        end else begin
            ior_d <= ior_s;
            iow_d <= iow_s;
        end
    end

    // Strobes are active low: a write starts as IOW falls, a read ends as IOR rises.
    assign data_sel  = AEN && (A == BASE_ADDR);
    assign stat_sel  = AEN && (A == STAT_ADDR);
    assign write_ev  = iow_d && !iow_s && data_sel;
    assign rd_end_ev = !ior_d && ior_s && data_sel;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:    if (write_ev) state_next = ALE_S;
            ALE_S:   if (cnt == ALE_LAST) state_next = START_S;
            START_S: if (cnt == START_LAST) state_next = WAIT_LO;
            WAIT_LO: begin
                if (!eoc_s) begin
                    state_next = WAIT_HI;
                end else if (cnt == TMO_LAST) begin
                    state_next = IDLE;
                    timed_out  = 1'b1;
                end
            end
            WAIT_HI: begin
                if (eoc_s) begin
                    state_next = RD_OE;
                end else if (cnt == TMO_LAST) begin
                    state_next = IDLE;
                    timed_out  = 1'b1;
                end
            end
            RD_OE: begin
                if (cnt == OE_LAST) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // START overlaps the final ALE cycle so the channel is latched as conversion begins.
    always_comb begin
        ALE   = 1'b0;
        START = 1'b0;
        OE    = 1'b0;
        case (state)
            ALE_S: begin
                ALE   = 1'b1;
                START = (cnt == ALE_LAST);
            end
            START_S: START = 1'b1;
            RD_OE:   OE    = 1'b1;
            default: ;
        endcase
    end

    // Later assignments win: a completion in the same cycle as a read-end keeps VALID set.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            addr  <= 3'd0;
            data  <= 8'h00;
            busy  <= 1'b0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (state == IDLE && write_ev) begin
                addr  <= DATAIN[2:0];
                busy  <= 1'b1;
                valid <= 1'b0;
                err   <= 1'b0;
            end
            if (rd_end_ev) begin
                valid <= 1'b0;
            end
            if (done) begin
                data  <= ADC_D;
                valid <= 1'b1;
                busy  <= 1'b0;
            end
            if (timed_out) begin
                err   <= 1'b1;
                valid <= 1'b0;
                busy  <= 1'b0;
            end
        end
    end

    assign ADDR  = addr;
    assign READ  = (data_sel || stat_sel) && !IOR;
    assign WRITE = data_sel && !IOW;

    always_comb begin
        status             = 8'h00;
        status[STAT_BUSY]  = busy;
        status[STAT_VALID] = valid;
        status[STAT_ERR]   = err;
        status[2:0]        = addr;
    end

    always_comb begin
        DATAOUT = 8'h00;
        if (READ) begin
            DATAOUT = stat_sel ? status : data;
        end
    end

`ifdef ADC_IRQ_EN
    logic irq;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            irq <= 1'b0;
        end else if (done || timed_out) begin
            irq <= 1'b1;
        end else if (rd_end_ev || write_ev) begin
            irq <= 1'b0;
        end
    end

    assign IRQ = irq;
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_ad_adc0809_ctrl.sv
// Directed self-checking bench for ad_adc0809_ctrl with a simple ADC0809 EOC model.
// IRQ expectations follow the ADC_IRQ_EN macro used for the build.
module tb_ad_adc0809_ctrl;

    localparam logic [9:0] BASE = 10'b0111111000;
    localparam logic [9:0] STAT = BASE + 10'd1;

    logic       CLK;
    logic       RST_N;
    logic       IOR;
    logic       IOW;
    logic       AEN;
    logic [9:0] A;
    logic [7:0] DATAIN;
    logic [7:0] DATAOUT;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADC_D;
    logic       EOC;
    logic       ALE;
    logic       START;
    logic       OE;
    logic [2:0] ADDR;
    logic       IRQ;

    int errors = 0;
    int checks = 0;

    logic eoc_auto = 1'b0;
    logic eoc_force = 1'b1;
    logic eoc_model = 1'b1;
    logic start_prev = 1'b0;
    int   eoc_timer = 0;
    int   ale_hi = 0, start_hi = 0, oe_hi = 0, irq_hi = 0;

    ad_adc0809_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .IOR(IOR), .IOW(IOW), .AEN(AEN), .A(A),
        .DATAIN(DATAIN), .DATAOUT(DATAOUT), .READ(READ), .WRITE(WRITE),
        .ADC_D(ADC_D), .EOC(EOC), .ALE(ALE), .START(START), .OE(OE),
        .ADDR(ADDR), .IRQ(IRQ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign EOC = eoc_auto ? eoc_model : eoc_force;

    // EOC drops 4 cycles after START falls and returns high 20 cycles later.
    always @(negedge CLK) begin
        if (start_prev && !START) begin
            eoc_timer = 1;
        end else if (eoc_timer != 0) begin
            eoc_timer++;
            if (eoc_timer == 5) eoc_model = 1'b0;
            if (eoc_timer == 25) begin
                eoc_model = 1'b1;
                eoc_timer = 0;
            end
        end
        start_prev = START;
    end

    always @(negedge CLK) begin
        if (ALE) ale_hi++;
        if (START) start_hi++;
        if (OE) oe_hi++;
        if (IRQ === 1'b1) irq_hi++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic cpu_out(input logic [9:0] addr, input logic [7:0] d);
        @(negedge CLK);
        AEN = 1'b1; A = addr; DATAIN = d; IOW = 1'b0;
        cycles(4);
        IOW = 1'b1;
        cycles(4);
        AEN = 1'b0;
    endtask

    task automatic cpu_in(input logic [9:0] addr, output logic [7:0] d, output logic rd);
        @(negedge CLK);
        AEN = 1'b1; A = addr; IOR = 1'b0;
        cycles(2);
        d  = DATAOUT;
        rd = READ;
        IOR = 1'b1;
        cycles(4);
        AEN = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (OE) begin
                seen = 1'b1;
            end else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int ale0;
        logic [7:0] d;
        logic rd;
        RST_N = 1'b0; IOR = 1'b1; IOW = 1'b1; AEN = 1'b0; A = '0; DATAIN = '0; ADC_D = 8'h00;
        cycles(3);
        checks++; if ({ALE, START, OE} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pins: got %b, expected 000", {ALE, START, OE}); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b, expected 0", IRQ); end
        ale0 = ale_hi;
        cpu_out(BASE, 8'h07);
        checks++; if (ale_hi - ale0 != 0) begin errors++; $display("[TB] FAIL reset_write_ignored: ale cycles %0d, expected 0", ale_hi - ale0); end
        checks++; if (ADDR !== 3'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, expected 0", ADDR); end
        RST_N = 1'b1;
        cycles(3);
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_status: got %h, expected 00", d); end
        checks++; if (rd !== 1'b1) begin errors++; $display("[TB] FAIL status_read_strobe: got %b, expected 1", rd); end
        cpu_in(BASE + 10'd2, d, rd);
        checks++; if ({rd, d} !== 9'h000) begin errors++; $display("[TB] FAIL off_port_read: got %h, expected 000", {rd, d}); end
    endtask

    task automatic test_normal();
        int ale0, st0, oe0;
        bit ok;
        logic [7:0] d;
        logic rd;
        ale0 = ale_hi; st0 = start_hi; oe0 = oe_hi;
        ADC_D = 8'hA7; eoc_auto = 1'b1;
        @(negedge CLK);
        AEN = 1'b1; A = BASE; DATAIN = 8'h05; IOW = 1'b0;
        #1;
        checks++; if (WRITE !== 1'b1) begin errors++; $display("[TB] FAIL write_strobe: got %b, expected 1", WRITE); end
        cycles(4);
        IOW = 1'b1;
        #1;
        checks++; if (WRITE !== 1'b0) begin errors++; $display("[TB] FAIL write_strobe_off: got %b, expected 0", WRITE); end
        cycles(4);
        AEN = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL normal_done: got no OE pulse, expected one"); end
        checks++; if (ADDR !== 3'd5) begin errors++; $display("[TB] FAIL normal_addr: got %0d, expected 5", ADDR); end
        checks++; if (ale_hi - ale0 != 2) begin errors++; $display("[TB] FAIL ale_width: got %0d, expected 2", ale_hi - ale0); end
        checks++; if (start_hi - st0 != 2) begin errors++; $display("[TB] FAIL start_width: got %0d, expected 2", start_hi - st0); end
        checks++; if (oe_hi - oe0 != 3) begin errors++; $display("[TB] FAIL oe_width: got %0d, expected 3", oe_hi - oe0); end
`ifdef ADC_IRQ_EN
        checks++; if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL irq_set: got %b, expected 1", IRQ); end
`endif
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h45) begin errors++; $display("[TB] FAIL normal_status: got %h, expected 45", d); end
        cpu_in(BASE, d, rd);
        checks++; if (d !== 8'hA7) begin errors++; $display("[TB] FAIL normal_data: got %h, expected a7", d); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b, expected 0", IRQ); end
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h05) begin errors++; $display("[TB] FAIL status_after_read: got %h, expected 05", d); end
    endtask

    task automatic test_write_while_busy();
        bit ok;
        logic [7:0] d;
        logic rd;
        ADC_D = 8'h3C; eoc_auto = 1'b1;
        cpu_out(BASE, 8'h05);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (EOC == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_eoc_low: got no EOC drop, expected one"); end
        cycles(3);
        cpu_out(BASE, 8'h02);
        checks++; if (ADDR !== 3'd5) begin errors++; $display("[TB] FAIL busy_addr: got %0d, expected 5", ADDR); end
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h85) begin errors++; $display("[TB] FAIL busy_status: got %h, expected 85", d); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_done: got no OE pulse, expected one"); end
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h45) begin errors++; $display("[TB] FAIL busy_final_status: got %h, expected 45", d); end
        cpu_in(BASE, d, rd);
        checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL busy_data: got %h, expected 3c", d); end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        logic rd;
        eoc_auto = 1'b0; eoc_force = 1'b1; ADC_D = 8'hFF;
        cpu_out(BASE, 8'h05);
        cycles(50);
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h85) begin errors++; $display("[TB] FAIL timeout_busy: got %h, expected 85", d); end
        cycles(4096);
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h25) begin errors++; $display("[TB] FAIL timeout_status: got %h, expected 25", d); end
        cpu_in(BASE, d, rd);
        checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL timeout_data_kept: got %h, expected 3c", d); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] d;
        logic rd;
        ADC_D = 8'hA7; eoc_auto = 1'b1;
        cpu_out(BASE, 8'h03);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (OE) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_oe_seen: got no OE, expected one"); end
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        checks++; if ({ALE, START, OE} !== 3'b000) begin errors++; $display("[TB] FAIL mid_reset_pins: got %b, expected 000", {ALE, START, OE}); end
        cycles(2);
        RST_N = 1'b1;
        cycles(2);
        checks++; if (ADDR !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_addr: got %0d, expected 0", ADDR); end
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_status: got %h, expected 00", d); end
        cpu_in(BASE, d, rd);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_data: got %h, expected 00", d); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] d;
        logic rd;
        eoc_auto = 1'b1;
        ADC_D = 8'h5A;
        cpu_out(BASE, 8'hF6);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_first_done: got no OE pulse, expected one"); end
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h46) begin errors++; $display("[TB] FAIL b2b_first_status: got %h, expected 46", d); end
        ADC_D = 8'hC3;
        cpu_out(BASE, 8'h01);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_second_done: got no OE pulse, expected one"); end
        cpu_in(STAT, d, rd);
        checks++; if (d !== 8'h41) begin errors++; $display("[TB] FAIL b2b_second_status: got %h, expected 41", d); end
        cpu_in(BASE, d, rd);
        checks++; if (d !== 8'hC3) begin errors++; $display("[TB] FAIL b2b_second_data: got %h, expected c3", d); end
`ifndef ADC_IRQ_EN
        checks++; if (irq_hi != 0) begin errors++; $display("[TB] FAIL irq_tied_low: got %0d high cycles, expected 0", irq_hi); end
`endif
    endtask

    initial begin
        test_reset();
        test_normal();
        test_write_while_busy();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
